// File: rtl/rover_drive_ctrl.sv
// rover_drive_ctrl
// Converts the navigation FSM state code into left/right wheel drive
// signals for an H-bridge. Direction reversals always go through a
// ramp-down to zero duty, a fixed brake dwell, then a ramp-up in the new
// direction, so the motors are never driven against their own momentum.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset
//   state  in   [2:0] navigation state code from the upstream FSM
//   pwm_l  out  left wheel PWM
//   pwm_r  out  right wheel PWM
//   dir_l  out  left direction (1 = forward, 0 = reverse)
//   dir_r  out  right direction (1 = forward, 0 = reverse)
//   brake  out  H-bridge brake enable
//   busy   out  drive not yet settled at its target
module rover_drive_ctrl #(
    parameter int PWM_BITS     = 8,
    parameter int MAX_DUTY     = 240,
    parameter int HALF_DUTY    = 120,
    parameter int TURN_DUTY    = 96,
    parameter int RAMP_STEP    = 16,
    parameter int RAMP_DIV     = 4,
    parameter int BRAKE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic       brake,
    output logic       busy
);

    localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int BRK_W = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RAMP_DIV - 1);
    localparam logic [BRK_W-1:0]    BRK_LOAD = BRK_W'(BRAKE_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(RAMP_STEP);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RAMP_DN = 2'd1,
        BRAKE   = 2'd2
    } fsm_t;

    // Target duty for a navigation code; STOP and HOLD request zero.
    function automatic logic [PWM_BITS-1:0] tgt_duty(input logic [2:0] code);
        case (code)
            3'b001:  return PWM_BITS'(MAX_DUTY);
            3'b010:  return PWM_BITS'(HALF_DUTY);
            3'b011:  return PWM_BITS'(TURN_DUTY);
            3'b100:  return PWM_BITS'(TURN_DUTY);
            3'b101:  return PWM_BITS'(HALF_DUTY);
            3'b110:  return PWM_BITS'(TURN_DUTY);
            default: return '0;
        endcase
    endfunction

    // Target directions as {dont_care, dir_l, dir_r}.
    function automatic logic [2:0] tgt_dirs(input logic [2:0] code);
        case (code)
            3'b001:  return 3'b011;
            3'b010:  return 3'b011;
            3'b011:  return 3'b001;
            3'b100:  return 3'b010;
            3'b101:  return 3'b000;
            3'b110:  return 3'b000;
            default: return 3'b111;
        endcase
    endfunction

    // One ramp step toward target; lands exactly on target when closer
    // than one step, so it can neither overshoot nor wrap.
    function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] tgt);
        if (cur < tgt) begin
            return ((tgt - cur) < STEP) ? tgt : cur + STEP;
        end else if (cur > tgt) begin
            return ((cur - tgt) < STEP) ? tgt : cur - STEP;
        end
        return cur;
    endfunction

    // Decrement by one step, saturating at zero.
    function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] cur);
        return (cur < STEP) ? '0 : cur - STEP;
    endfunction

    logic [2:0]          state_q;
    fsm_t                fsm;
    logic [PWM_BITS-1:0] duty;
    logic [BRK_W-1:0]    brk_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic [2:0]          cur_dirs;
    logic [PWM_BITS-1:0] cur_duty;
    logic                dir_match;
    logic                tick;

    fsm_t                nxt_fsm;
    logic [PWM_BITS-1:0] nxt_duty;
    logic                nxt_dir_l;
    logic                nxt_dir_r;
    logic [BRK_W-1:0]    nxt_brk;
    logic [DIV_W-1:0]    nxt_div;
    logic [PWM_BITS-1:0] nxt_pwm;
    logic                nxt_pwm_on;
    logic                nxt_brake;
    logic                nxt_busy;

    assign cur_dirs  = tgt_dirs(state_q);
    assign cur_duty  = tgt_duty(state_q);
    assign dir_match = cur_dirs[2] || ((cur_dirs[1] == dir_l) && (cur_dirs[0] == dir_r));
    assign tick      = (div_cnt == DIV_LAST);

    always_comb begin
        nxt_fsm   = fsm;
        nxt_duty  = duty;
        nxt_dir_l = dir_l;
        nxt_dir_r = dir_r;
        nxt_brk   = brk_cnt;
        case (fsm)
            RUN: begin
                if (!dir_match) begin
                    nxt_fsm = RAMP_DN;
                end else if (tick) begin
                    nxt_duty = ramp_toward(duty, cur_duty);
                end
            end
            RAMP_DN: begin
                // Runs to zero regardless of what the target does meanwhile.
                if (duty == '0) begin
                    nxt_fsm = BRAKE;
                    nxt_brk = BRK_LOAD;
                end else if (tick) begin
                    nxt_duty = sat_dec(duty);
                end
            end
            BRAKE: begin
                if (brk_cnt == '0) begin
                    if (!cur_dirs[2]) begin
                        nxt_dir_l = cur_dirs[1];
                        nxt_dir_r = cur_dirs[0];
                    end
                    nxt_fsm = RUN;
                end else begin
                    nxt_brk = brk_cnt - 1'b1;
                end
            end
            default: nxt_fsm = RUN;
        endcase

        nxt_div = tick ? '0 : div_cnt + 1'b1;
        nxt_pwm = pwm_cnt + 1'b1;

        // Outputs are registered from next-state values so they line up
        // with the internal state they describe, without an extra cycle.
        nxt_pwm_on = (nxt_pwm < nxt_duty) && (nxt_fsm != BRAKE);
        nxt_brake  = (nxt_fsm == BRAKE) ||
                     ((nxt_fsm == RUN) && (nxt_duty == '0) && (state == 3'b111));
        nxt_busy   = (nxt_fsm != RUN) || (nxt_duty != tgt_duty(state));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= 3'b000;
            fsm     <= RUN;
            duty    <= '0;
            brk_cnt <= '0;
            div_cnt <= '0;
            pwm_cnt <= '0;
            dir_l   <= 1'b1;
            dir_r   <= 1'b1;
            pwm_l   <= 1'b0;
            pwm_r   <= 1'b0;
            brake   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state;
            fsm     <= nxt_fsm;
            duty    <= nxt_duty;
            brk_cnt <= nxt_brk;
            div_cnt <= nxt_div;
            pwm_cnt <= nxt_pwm;
            dir_l   <= nxt_dir_l;
            dir_r   <= nxt_dir_r;
            pwm_l   <= nxt_pwm_on;
            pwm_r   <= nxt_pwm_on;
            brake   <= nxt_brake;
            busy    <= nxt_busy;
        end
    end

endmodule

// File: tb/tb_rover_drive_ctrl.sv
// Self-checking bench for rover_drive_ctrl: a cycle-level scoreboard
// compares every output each clock, a table of navigation codes checks
// settled direction, duty and brake behaviour, and hand-written sequences
// cover ramp-up timing from reset and reset during the brake dwell.
module tb_rover_drive_ctrl;

    localparam int RSTEP = 16;
    localparam int RDIV  = 4;
    localparam int BRKC  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] state;
    logic       pwm_l, pwm_r, dir_l, dir_r, brake, busy;

    int checks;
    int failures;
    int cyc;

    rover_drive_ctrl #(
        .PWM_BITS(8), .MAX_DUTY(240), .HALF_DUTY(120), .TURN_DUTY(96),
        .RAMP_STEP(RSTEP), .RAMP_DIV(RDIV), .BRAKE_CYCLES(BRKC)
    ) dut (
        .clk(clk), .reset(reset), .state(state),
        .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
        .brake(brake), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model state (0 = RUN, 1 = RAMP_DN, 2 = BRAKE).
    int m_sq, m_duty, m_fsm, m_dl, m_dr, m_brk, m_div, m_pc;
    logic [5:0] exp_q[$];

    task automatic decode(input int code, output int dc, output int dl,
                          output int dr, output int duty);
        dc = 0; dl = 1; dr = 1; duty = 0;
        case (code)
            1: duty = 240;
            2: duty = 120;
            3: begin dl = 0; duty = 96; end
            4: begin dr = 0; duty = 96; end
            5: begin dl = 0; dr = 0; duty = 120; end
            6: begin dl = 0; dr = 0; duty = 96; end
            default: dc = 1;
        endcase
    endtask

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, expv);
        end
    endtask

    // Advance the model with the inputs about to be sampled, queue the
    // expected outputs, clock the DUT and compare.
    task automatic cycle();
        int dc, dl, dr, td, diff;
        logic [5:0] exp_v, got_v;
        logic e_pwm, e_brk, e_busy;
        if (reset) begin
            m_sq = 0; m_duty = 0; m_fsm = 0; m_dl = 1; m_dr = 1;
            m_brk = 0; m_div = 0; m_pc = 0;
        end else begin
            decode(m_sq, dc, dl, dr, td);
            case (m_fsm)
                0: begin
                    if (!(dc == 1 || (dl == m_dl && dr == m_dr))) m_fsm = 1;
                    else if (m_div == RDIV - 1) begin
                        diff = (td > m_duty) ? td - m_duty : m_duty - td;
                        if (diff < RSTEP) m_duty = td;
                        else if (td > m_duty) m_duty = m_duty + RSTEP;
                        else m_duty = m_duty - RSTEP;
                    end
                end
                1: begin
                    if (m_duty == 0) begin m_fsm = 2; m_brk = BRKC - 1; end
                    else if (m_div == RDIV - 1)
                        m_duty = (m_duty < RSTEP) ? 0 : m_duty - RSTEP;
                end
                default: begin
                    if (m_brk == 0) begin
                        if (dc == 0) begin m_dl = dl; m_dr = dr; end
                        m_fsm = 0;
                    end else m_brk = m_brk - 1;
                end
            endcase
            m_div = (m_div + 1) % RDIV;
            m_pc  = (m_pc + 1) % 256;
            m_sq  = int'(state);
        end
        decode(m_sq, dc, dl, dr, td);
        e_pwm  = (m_pc < m_duty) && (m_fsm != 2);
        e_brk  = (m_fsm == 2) || (m_fsm == 0 && m_duty == 0 && m_sq == 7);
        e_busy = (m_fsm != 0) || (m_duty != td);
        exp_v = {e_pwm, e_pwm, m_dl[0], m_dr[0], e_brk, e_busy};
        exp_q.push_back(exp_v);
        @(posedge clk);
        #1;
        cyc++;
        got_v = {pwm_l, pwm_r, dir_l, dir_r, brake, busy};
        exp_v = exp_q.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL scoreboard cyc=%0d got=%b expected=%b (pwm_l pwm_r dir_l dir_r brake busy)",
                     cyc, got_v, exp_v);
        end
    endtask

    // Wait for busy to clear (at least two clocks for the new code to land),
    // counting clocks with brake asserted on the way.
    task automatic settle(output int brk_n, output bit ok);
        brk_n = 0;
        ok = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            cycle();
            if (brake) brk_n++;
            if (i >= 2 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic window(output int hi, output int brk_n, output int diff);
        hi = 0; brk_n = 0; diff = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (pwm_l) hi++;
            if (brake) brk_n++;
            if (pwm_r !== pwm_l) diff++;
        end
    endtask

    typedef struct {
        logic [2:0] st;
        int         dl;
        int         dr;
        int         brk_settle;
        int         hi;
        int         brk_win;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, brk_n, hi, diff, bad;
        bit ok;
        logic [5:0] got_v;

        // state, dir_l, dir_r, brake clocks while settling, pwm high/256, brake clocks/256
        tbl[0] = '{3'b101, 0, 0, 8, 120, 0};
        tbl[1] = '{3'b111, 0, 0, 1, 0, 256};
        tbl[2] = '{3'b001, 1, 1, 8, 240, 0};
        tbl[3] = '{3'b111, 1, 1, 1, 0, 256};
        tbl[4] = '{3'b001, 1, 1, 0, 240, 0};
        tbl[5] = '{3'b011, 0, 1, 8, 96, 0};
        tbl[6] = '{3'b100, 1, 0, 8, 96, 0};
        tbl[7] = '{3'b110, 0, 0, 8, 96, 0};
        tbl[8] = '{3'b010, 1, 1, 8, 120, 0};
        tbl[9] = '{3'b000, 1, 1, 0, 0, 0};

        checks = 0; failures = 0; cyc = 0;
        m_sq = 0; m_duty = 0; m_fsm = 0; m_dl = 1; m_dr = 1;
        m_brk = 0; m_div = 0; m_pc = 0;
        reset = 1'b1;
        state = 3'b000;
        repeat (3) cycle();
        got_v = {pwm_l, pwm_r, dir_l, dir_r, brake, busy};
        check("reset_outputs", int'(got_v), int'(6'b001100));

        // Ramp-up from reset: 15 ticks of 4 clocks to reach 240.
        reset = 1'b0;
        state = 3'b001;
        n = 0; brk_n = 0; ok = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            cycle();
            n = i;
            if (brake) brk_n++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            $display("FAIL rampup_timeout got=busy expected=settled");
        end
        check("rampup_clocks", n, 60);
        check("rampup_brake", brk_n, 0);
        check("rampup_dirs", int'({dir_l, dir_r}), 3);

        foreach (tbl[k]) begin
            state = tbl[k].st;
            settle(brk_n, ok);
            if (!ok) begin
                failures++;
                $display("FAIL settle_timeout[%0d] got=busy expected=settled", k);
            end
            check($sformatf("settle_brake[%0d]", k), brk_n, tbl[k].brk_settle);
            check($sformatf("dir_l[%0d]", k), int'(dir_l), tbl[k].dl);
            check($sformatf("dir_r[%0d]", k), int'(dir_r), tbl[k].dr);
            window(hi, brk_n, diff);
            check($sformatf("pwm_high[%0d]", k), hi, tbl[k].hi);
            check($sformatf("window_brake[%0d]", k), brk_n, tbl[k].brk_win);
            check($sformatf("pwm_lr_equal[%0d]", k), diff, 0);
        end

        // Reset on the 4th clock of a brake dwell.
        state = 3'b101;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (brake) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            failures++;
            $display("FAIL brake_entry_timeout got=0 expected=brake");
        end
        repeat (3) cycle();
        check("brake_4th_clock", int'(brake), 1);
        check("brake_4th_pwm", int'({pwm_l, pwm_r}), 0);
        reset = 1'b1;
        state = 3'b000;
        cycle();
        got_v = {pwm_l, pwm_r, dir_l, dir_r, brake, busy};
        check("reset_mid_brake", int'(got_v), int'(6'b001100));
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            got_v = {pwm_l, pwm_r, dir_l, dir_r, brake, busy};
            if (got_v !== 6'b001100) bad++;
        end
        check("static_after_reset", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rover_drive_ctrl.md
Name: rover_drive_ctrl

Overview:
- Downstream stage of the land-rover navigation FSM. Consumes its 3-bit state code and produces motor drive signals for left and right wheels: direction, PWM and brake.
- Enforces a safe reversal sequence: ramp down, brake dwell, switch direction, ramp up.
- Sits between the navigation FSM and the H-bridge pins.

Parameters:
- PWM_BITS, 8: width of the PWM counter and duty register.
- MAX_DUTY, 240: duty for full-speed codes.
- HALF_DUTY, 120: duty for slow and reverse codes.
- TURN_DUTY, 96: duty for turn codes.
- RAMP_STEP, 16: duty change per ramp tick.
- RAMP_DIV, 4: clocks per ramp tick.
- BRAKE_CYCLES, 8: brake dwell length in clocks.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- state  in  3  navigation state code from upstream FSM
- pwm_l  out  1  left wheel PWM
- pwm_r  out  1  right wheel PWM
- dir_l  out  1  left direction (1 = forward, 0 = reverse)
- dir_r  out  1  right direction (1 = forward, 0 = reverse)
- brake  out  1  H-bridge brake enable
- busy  out  1  drive not yet settled at target

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high, sampled on the posedge of clk only.
- Input register: state is registered into state_q every clock. All decisions use state_q, giving one clock of input latency.
- Decode of state_q (target dir_l/dir_r, target duty):
  - 000 STOP: dirs don't-care, duty 0
  - 001 FWD: 1/1, MAX_DUTY
  - 010 FWD_SLOW: 1/1, HALF_DUTY
  - 011 TURN_L: 0/1, TURN_DUTY
  - 100 TURN_R: 1/0, TURN_DUTY
  - 101 REV: 0/0, HALF_DUTY
  - 110 REV_SLOW: 0/0, TURN_DUTY
  - 111 HOLD: dirs don't-care, duty 0
- Dir match: a don't-care target always matches the current dirs.
- Ramp tick: div_cnt is free-running 0..RAMP_DIV-1. tick = (div_cnt == RAMP_DIV-1). div_cnt is not reset by state changes.
- Control FSM states: RUN, RAMP_DN, BRAKE.
- RUN:
  - If target dirs match current dirs, on each tick duty moves toward target by RAMP_STEP. If |target - duty| < RAMP_STEP, duty is loaded with target exactly. No overshoot, no wrap.
  - If dirs mismatch, go to RAMP_DN. Take no duty step that cycle.
- RAMP_DN:
  - On each tick duty decreases by RAMP_STEP, saturating at 0.
  - When duty == 0, go to BRAKE and load brk_cnt = BRAKE_CYCLES-1.
  - RAMP_DN always completes to 0, even if the target changes mid-ramp.
- BRAKE:
  - brake = 1 and pwm forced to 0.
  - brk_cnt decrements each clock, independent of tick.
  - When brk_cnt == 0, latch current dirs from the decode of state_q in that cycle (don't-care keeps old value) and go to RUN.
  - Length is exactly BRAKE_CYCLES clocks.
- brake output: 1 in BRAKE. Also 1 in RUN when duty == 0 and state_q == 111. Otherwise 0.
- PWM:
  - pwm_cnt is a free-running PWM_BITS counter that wraps 2^PWM_BITS-1 to 0.
  - pwm_l = pwm_r = (pwm_cnt < duty) and not BRAKE.
  - High time per period is duty/2^PWM_BITS; 100% duty is never reached.
- busy = (fsm != RUN) or (duty != target duty).
- Reset values:
  - Outputs: pwm_l = pwm_r = 0, dir_l = dir_r = 1, brake = 0, busy = 0.
  - Internal: duty = 0, fsm = RUN, state_q = 000, and div_cnt, pwm_cnt, brk_cnt all 0.
  - Reset in any FSM state, including mid-BRAKE or mid-ramp, returns to this condition on the next edge.
- Simultaneous events:
  - A new target while duty equals the old target takes effect next clock.
  - A target change during BRAKE is honoured only through the dir latch at BRAKE exit.

Test Plan:
- Reset release, state = 001 → dirs 1/1, duty steps 16, 32, … reaching 240 after 15 ticks (60 clocks). busy stays 1 until duty = 240, then 0. brake stays 0.
- At duty 240, state = 101 → RAMP_DN 15 ticks to 0, then brake = 1 for exactly 8 clocks with pwm = 0. Dirs then switch to 0/0 and duty ramps 16…112, then clamps to 120 on the 8th tick.
- Steady duty 120 → pwm_l is high on exactly 120 of every 256 consecutive clocks, and pwm_r equals pwm_l.
- At speed 240 fwd, state = 111 → ramp to 0 with no BRAKE dwell (dirs match). Then brake = 1 is held while HOLD persists, dirs stay 1/1. state = 001 → brake drops and ramp-up restarts.
- From FWD at 240, state = 011 → ramp down, brake for 8 clocks, dir_l = 0, dir_r = 1, ramp to 96.
- Assert reset during the 4th BRAKE clock → next edge gives brake = 0, duty = 0, dirs 1/1, busy = 0. With state held at 000, outputs stay static.
